// File: rtl/el_lfib_gen_if.sv
// Handshake/bus bundle for el_lfib_gen: run control, dual-rail output link and status.
interface el_lfib_gen_if #(
  parameter int WIDTH    = 32,
  parameter int RAIL_NUM = 2,
  parameter int CNT_W    = 16
) ();
  logic                      start;
  logic                      mode;
  logic [WIDTH-1:0]          seed;
  logic [CNT_W-1:0]          len;
  logic                      ack_i;
  logic [RAIL_NUM*WIDTH-1:0] out;
  logic                      busy;
  logic                      done;
  logic                      ovf;
  logic [CNT_W-1:0]          count;

  modport master (
    output start, mode, seed, len, ack_i,
    input  out, busy, done, ovf, count
  );

  modport slave (
    input  start, mode, seed, len, ack_i,
    output out, busy, done, ovf, count
  );
endinterface

// File: rtl/el_lfib_gen.sv
// Generalised ORDER-bonacci generator emitting each term on a dual-rail,
// four-phase return-to-zero link driven straight from a register.
module el_lfib_gen #(
  parameter int WIDTH       = 32,
  parameter int ORDER       = 2,
  parameter int RAIL_NUM    = 2,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  el_lfib_gen_if.slave bus
);
  localparam int SUM_W = WIDTH + $clog2(ORDER);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL, S_DONE} state_t;

  state_t                    state_reg, state_next;
  logic [WIDTH-1:0]          h_reg  [ORDER];
  logic [WIDTH-1:0]          h_next [ORDER];
  logic [SYNC_STAGES-1:0]    ack_sync_reg;
  logic                      ack_s;
  logic                      mode_reg, mode_next;
  logic [CNT_W-1:0]          len_reg, len_next;
  logic [CNT_W-1:0]          count_reg, count_next, count_inc;
  logic                      ovf_reg, ovf_next;
  logic [RAIL_NUM*WIDTH-1:0] out_reg, out_next;
  logic [SUM_W-1:0]          sum;
  logic                      sum_ovf;

  assign ack_s     = ack_sync_reg[SYNC_STAGES-1];
  assign count_inc = count_reg + 1'b1;

  always_comb begin
    sum = '0;
    for (int k = 0; k < ORDER; k++) begin
      sum = sum + SUM_W'(h_reg[k]);
    end
    sum_ovf = |sum[SUM_W-1:WIDTH];
  end

  always_comb begin
    state_next = state_reg;
    h_next     = h_reg;
    mode_next  = mode_reg;
    len_next   = len_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          h_next[0] = bus.seed;
          for (int k = 1; k < ORDER; k++) begin
            h_next[k] = '0;
          end
          mode_next  = bus.mode;
          len_next   = bus.len;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (ack_s) begin
          state_next = S_NULL;
        end
      end
      S_NULL: begin
        if (!ack_s) begin
          count_next = count_inc;
          if ((len_reg != '0) && (count_inc == len_reg)) begin
            state_next = S_DONE;
          end else if (mode_reg && sum_ovf) begin
            ovf_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            h_next[0] = sum[WIDTH-1:0];
            for (int k = 1; k < ORDER; k++) begin
              h_next[k] = h_reg[k-1];
            end
            state_next = S_DATA;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output rails are computed from the next state so the link register
  // switches on the same edge as the FSM and never shows a partial word.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rail
    assign out_next[RAIL_NUM*gi]   = (state_next == S_DATA) &  h_next[0][gi];
    assign out_next[RAIL_NUM*gi+1] = (state_next == S_DATA) & ~h_next[0][gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ack_sync_reg <= '0;
      mode_reg     <= 1'b0;
      len_reg      <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      out_reg      <= '0;
      for (int k = 0; k < ORDER; k++) begin
        h_reg[k] <= '0;
      end
    end else begin
      state_reg    <= state_next;
      ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], bus.ack_i};
      mode_reg     <= mode_next;
      len_reg      <= len_next;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
      out_reg      <= out_next;
      for (int k = 0; k < ORDER; k++) begin
        h_reg[k] <= h_next[k];
      end
    end
  end

  assign bus.out   = out_reg;
  assign bus.busy  = (state_reg == S_DATA) || (state_reg == S_NULL);
  assign bus.done  = (state_reg == S_DONE);
  assign bus.ovf   = ovf_reg;
  assign bus.count = count_reg;
endmodule
